// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a 256-bit cache line port to a 64-bit burst
// memory port. A fill collects four beats into the line buffer. A writeback
// serializes a latched line into four beats. Only one transaction is in
// flight at a time.
//
// Optional build macro: CACHELINE_ADAPTOR_PERF_CNT_EN adds rd_cnt_o/wr_cnt_o,
// which count completed fills and completed writebacks.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
   ,output logic [31:0]            rd_cnt_o
   ,output logic [31:0]            wr_cnt_o
`endif
);

    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int BW_LOG = $clog2(BURST_WIDTH);
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      ONE_BEAT   = CNT_W'(1);
    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        beat_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    read_q;
    logic                    write_q;
    logic                    resp_q;

    logic [CNT_W+BW_LOG-1:0] beat_base_s;
    logic [BURST_WIDTH-1:0]  burst_s;

    // Bit offset of the current beat inside the line buffer, plus the write beat mux.
    always_comb begin
        beat_base_s = {beat_q, {BW_LOG{1'b0}}};
        burst_s     = {BURST_WIDTH{1'b0}};
        if (state_q == WR_BURST) begin
            burst_s = line_q[beat_base_s +: BURST_WIDTH];
        end else begin
            burst_s = {BURST_WIDTH{1'b0}};
        end
    end

    // Transaction FSM: accepts a request, runs the burst, then pulses resp_o once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= {CNT_W{1'b0}};
            line_q  <= {LINE_WIDTH{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Writeback wins so a dirty victim leaves before its refill arrives.
                    if (write_i) begin
                        line_q  <= line_i;
                        addr_q  <= address_i;
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= address_i;
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_q[beat_base_s +: BURST_WIDTH] <= burst_i;
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= {CNT_W{1'b0}};
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + ONE_BEAT;
                        end
                    end else begin
                        beat_q <= beat_q;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= {CNT_W{1'b0}};
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + ONE_BEAT;
                        end
                    end else begin
                        beat_q <= beat_q;
                    end
                end
                DONE: begin
                    // Requests are ignored here, forcing one idle cycle between transactions.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign line_o    = line_q;
    assign burst_o   = burst_s;
    assign address_o = addr_q & ALIGN_MASK;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    logic        is_wr_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Completion counters: bump the matching counter on the resp_o cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr_q  <= 1'b0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            if (state_q == IDLE) begin
                is_wr_q <= write_i;
            end else begin
                is_wr_q <= is_wr_q;
            end
            if (state_q == DONE) begin
                if (is_wr_q) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                end
            end else begin
                rd_cnt_q <= rd_cnt_q;
                wr_cnt_q <= wr_cnt_q;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule
